// File: rtl/seg7_scan_ctrl_if.sv
// rtl/seg7_scan_ctrl_if.sv - load/display signal bundle for the 7-segment scan controller
interface seg7_scan_ctrl_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] i_data;
  logic [DIGITS-1:0]   i_dp;
  logic                i_load;
  logic [3:0]          o_dig;
  logic [DIGITS-1:0]   o_sel;
  logic                o_dp;
  logic                o_frame;

  modport master (
    output i_data, i_dp, i_load,
    input  o_dig, o_sel, o_dp, o_frame
  );

  modport slave (
    input  i_data, i_dp, i_load,
    output o_dig, o_sel, o_dp, o_frame
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multiplexed 7-segment scan with frame-synchronous double buffering
// Optional leading-zero blanking is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_scan_ctrl #(
  parameter int DIGITS  = 4,
  parameter int DIV_CNT = 50000,
  parameter int GUARD   = 500
) (
  input  logic            clk,
  input  logic            rst_n,
  seg7_scan_ctrl_if.slave bus
);
  localparam int PW = (DIV_CNT > 1) ? $clog2(DIV_CNT) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PMAX    = PW'(DIV_CNT - 1);
  localparam logic [PW-1:0] GUARD_V = PW'(GUARD);
  localparam logic [IW-1:0] IMAX    = IW'(DIGITS - 1);

  logic [PW-1:0]       pcnt;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] shadow_data, disp_data;
  logic [DIGITS-1:0]   shadow_dp, disp_dp;
  logic                slot_end, frame_end, digit_blank;
  logic [DIGITS-1:0]   sel_nxt;
  logic [3:0]          dig_nxt;
  logic                dp_nxt;

  assign slot_end  = (pcnt == PMAX);
  assign frame_end = slot_end && (idx == IMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
      idx  <= '0;
    end else if (slot_end) begin
      pcnt <= '0;
      idx  <= frame_end ? '0 : idx + 1'b1;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // A load coinciding with the frame wrap goes straight to the display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_data <= '0;
      shadow_dp   <= '0;
      disp_data   <= '0;
      disp_dp     <= '0;
    end else begin
      if (bus.i_load) begin
        shadow_data <= bus.i_data;
        shadow_dp   <= bus.i_dp;
      end
      if (frame_end) begin
        disp_data <= bus.i_load ? bus.i_data : shadow_data;
        disp_dp   <= bus.i_load ? bus.i_dp   : shadow_dp;
      end
    end
  end

`ifdef SEG7_LZ_BLANK_EN
  logic [DIGITS-1:0] blank;
  logic              upper_zero;

  // Walk down from the top digit; digit 0 is never blanked.
  always_comb begin
    blank      = '0;
    upper_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      upper_zero = upper_zero && (disp_data[4*k +: 4] == 4'h0);
      blank[k]   = upper_zero && !disp_dp[k];
    end
  end

  assign digit_blank = blank[idx];
`else
  assign digit_blank = 1'b0;
`endif

  always_comb begin
    sel_nxt = '1;
    dp_nxt  = 1'b1;
    dig_nxt = disp_data[{idx, 2'b00} +: 4];
    if ((pcnt >= GUARD_V) && !digit_blank) begin
      sel_nxt[idx] = 1'b0;
      dp_nxt       = ~disp_dp[idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.o_sel   <= '1;
      bus.o_dig   <= 4'h0;
      bus.o_dp    <= 1'b1;
      bus.o_frame <= 1'b0;
    end else begin
      bus.o_sel   <= sel_nxt;
      bus.o_dig   <= dig_nxt;
      bus.o_dp    <= dp_nxt;
      bus.o_frame <= frame_end;
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - self-checking bench for seg7_scan_ctrl (DIGITS=4, DIV_CNT=8, GUARD=2)
module tb_seg7_scan_ctrl;
  localparam int NDIG  = 4;
  localparam int DIV   = 8;
  localparam int GRD   = 2;
  localparam int FRAME = NDIG * DIV;
`ifdef SEG7_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  typedef struct {
    int          en;
    logic [15:0] data;
    logic [3:0]  dp;
  } load_t;

  logic clk;
  logic rst_n;
  logic check_en;
  int   ecount;
  int   nchecks;
  int   nerr;
  load_t loads[$];

  seg7_scan_ctrl_if #(.DIGITS(NDIG)) bus ();

  seg7_scan_ctrl #(.DIGITS(NDIG), .DIV_CNT(DIV), .GUARD(GRD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Edge counter since reset release plus a log of sampled loads.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ecount <= 0;
      loads.delete();
    end else begin
      ecount <= ecount + 1;
      if (bus.i_load) loads.push_back('{ecount + 1, bus.i_data, bus.i_dp});
    end
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s n=%0d got=%h exp=%h", name, ecount, got, exp);
    end
  endtask

  // Display contents seen by the state before edge s+1: the last load at or
  // before the most recent frame-wrap commit edge (multiple of FRAME, > 0).
  function automatic logic [19:0] model_disp(input int s);
    int c;
    logic [19:0] v;
    c = (s / FRAME) * FRAME;
    v = '0;
    if (c > 0)
      foreach (loads[i]) if (loads[i].en <= c) v = {loads[i].dp, loads[i].data};
    return v;
  endfunction

  function automatic bit model_blank(input logic [19:0] v, input int k);
    if (!LZ || k == 0) return 1'b0;
    return ((v[15:0] >> (4 * k)) == 16'h0) && !v[16 + k];
  endfunction

  int          m_s, m_pc, m_ix;
  logic [19:0] m_v;
  logic [3:0]  m_sel, m_dig;
  logic        m_dp, m_fr;

  always @(negedge clk) begin
    if (check_en) begin
      if (ecount == 0) begin
        m_sel = 4'hF; m_dig = 4'h0; m_dp = 1'b1; m_fr = 1'b0;
      end else begin
        m_s   = ecount - 1;
        m_pc  = m_s % DIV;
        m_ix  = (m_s / DIV) % NDIG;
        m_v   = model_disp(m_s);
        m_dig = m_v[m_ix*4 +: 4];
        m_fr  = (ecount % FRAME) == 0;
        if (m_pc < GRD || model_blank(m_v, m_ix)) begin
          m_sel = 4'hF; m_dp = 1'b1;
        end else begin
          m_sel = ~(4'b0001 << m_ix);
          m_dp  = ~m_v[16 + m_ix];
        end
      end
      check("model_sel",   16'(bus.o_sel),   16'(m_sel));
      check("model_dig",   16'(bus.o_dig),   16'(m_dig));
      check("model_dp",    16'(bus.o_dp),    16'(m_dp));
      check("model_frame", 16'(bus.o_frame), 16'(m_fr));
    end
  end

  task automatic at_cycle(input int n);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (ecount >= n) break;
    end
    check("reach_cycle", 16'(ecount), 16'(n));
  endtask

  // Present a load after edge e so that edge e+1 samples it.
  task automatic drive_load(input int e, input logic [15:0] d, input logic [3:0] p);
    for (int i = 0; i < 2000 && ecount < e; i++) begin
      @(posedge clk);
      #1;
    end
    check("load_slot", 16'(ecount), 16'(e));
    bus.i_data = d;
    bus.i_dp   = p;
    bus.i_load = 1'b1;
    @(posedge clk);
    #1;
    bus.i_load = 1'b0;
  endtask

  initial begin
    nchecks = 0; nerr = 0; check_en = 1'b0;
    bus.i_data = '0; bus.i_dp = '0; bus.i_load = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_en = 1'b1;
    repeat (2) @(posedge clk);
    #5 rst_n = 1'b1;

    at_cycle(0);  check("idle_sel0",  16'(bus.o_sel), 16'hF);
    at_cycle(2);  check("idle_sel2",  16'(bus.o_sel), 16'hF);
    at_cycle(3);  check("idle_sel3",  16'(bus.o_sel), 16'hE);
    check("idle_dig3", 16'(bus.o_dig), 16'h0);
    check("idle_dp3",  16'(bus.o_dp),  16'h1);
    at_cycle(8);  check("idle_sel8",  16'(bus.o_sel), 16'hE);
    at_cycle(9);  check("idle_sel9",  16'(bus.o_sel), 16'hF);
    at_cycle(11); check("idle_sel11", 16'(bus.o_sel), LZ ? 16'hF : 16'hD);
    at_cycle(32); check("idle_frame", 16'(bus.o_frame), 16'h1);

    drive_load(40, 16'h1A3F, 4'b0100);
    at_cycle(60); check("pre_commit_dig", 16'(bus.o_dig), 16'h0);
    at_cycle(64); check("frame_64", 16'(bus.o_frame), 16'h1);
    at_cycle(67); check("d0_sel", 16'(bus.o_sel), 16'hE);
    check("d0_dig", 16'(bus.o_dig), 16'hF);
    check("d0_dp",  16'(bus.o_dp),  16'h1);
    at_cycle(75); check("d1_dig", 16'(bus.o_dig), 16'h3);
    at_cycle(83); check("d2_sel", 16'(bus.o_sel), 16'hB);
    check("d2_dig", 16'(bus.o_dig), 16'hA);
    check("d2_dp",  16'(bus.o_dp),  16'h0);
    at_cycle(91); check("d3_dig", 16'(bus.o_dig), 16'h1);
    check("d3_dp",  16'(bus.o_dp),  16'h1);

    drive_load(100, 16'h1111, 4'b0000);
    drive_load(110, 16'h2222, 4'b0000);
    at_cycle(120); check("hold_old_dig", 16'(bus.o_dig), 16'hA);
    at_cycle(131); check("last_load_dig", 16'(bus.o_dig), 16'h2);

    at_cycle(155); check("pre_bypass_dig", 16'(bus.o_dig), 16'h2);
    drive_load(159, 16'h5555, 4'b0000);
    at_cycle(160); check("bypass_frame", 16'(bus.o_frame), 16'h1);
    at_cycle(163); check("bypass_sel", 16'(bus.o_sel), 16'hE);
    check("bypass_dig", 16'(bus.o_dig), 16'h5);

    at_cycle(213); check("pre_rst_sel", 16'(bus.o_sel), 16'hB);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_sel", 16'(bus.o_sel), 16'hF);
    check("async_rst_dig", 16'(bus.o_dig), 16'h0);
    check("async_rst_dp",  16'(bus.o_dp),  16'h1);
    repeat (3) @(posedge clk);
    #5 rst_n = 1'b1;
    at_cycle(3);  check("restart_sel", 16'(bus.o_sel), 16'hE);
    check("restart_dig", 16'(bus.o_dig), 16'h0);
    at_cycle(11); check("restart_sel1", 16'(bus.o_sel), LZ ? 16'hF : 16'hD);

    drive_load(12, 16'h0070, 4'b1000);
    at_cycle(32); check("lz_frame", 16'(bus.o_frame), 16'h1);
    at_cycle(35); check("lz_d0_sel", 16'(bus.o_sel), 16'hE);
    check("lz_d0_dig", 16'(bus.o_dig), 16'h0);
    at_cycle(43); check("lz_d1_sel", 16'(bus.o_sel), 16'hD);
    check("lz_d1_dig", 16'(bus.o_dig), 16'h7);
    at_cycle(51); check("lz_d2_sel", 16'(bus.o_sel), LZ ? 16'hF : 16'hB);
    check("lz_d2_dp",  16'(bus.o_dp), 16'h1);
    at_cycle(59); check("lz_d3_sel", 16'(bus.o_sel), 16'h7);
    check("lz_d3_dig", 16'(bus.o_dig), 16'h0);
    check("lz_d3_dp",  16'(bus.o_dp),  16'h0);

    at_cycle(70);
    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end
endmodule
